lab2_proc_bypass_regfile: RTL

Parametrised register file with an integrated bypass network and pending-write scoreboard for the pipelined TinyRV2 processor. It is the next-generation D-stage operand source and replaces the plain 2-read/1-write zero register file. It returns the youngest in-flight value for each read port and raises a per-port stall when a needed value is not yet available. Long-latency units (iterative mul/div) mark destinations pending at issue; the mark clears when the unit's write retires.

---
 rtl/lab2_proc_pkg.sv | 15 +
 rtl/lab2_proc_BypassSelVRTL.sv | 48 ++++
 rtl/lab2_proc_bypass_regfile.sv | 100 ++++++++++
 3 files changed

// File: rtl/lab2_proc_pkg.sv
// Shared definitions for the TinyRV2 pipelined processor datapath:
// bypass-stage indices and the register-address width helper.
package lab2_proc_pkg;

    // Bypass source indices, youngest first
    localparam int BYP_X = 0;
    localparam int BYP_M = 1;
    localparam int BYP_W = 2;

    // Address width for a register file of nregs entries, at least one bit
    function automatic int addr_width(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/lab2_proc_BypassSelVRTL.sv
// Single-read-port operand resolver: picks the youngest in-flight producer,
// then the write port, then storage, and reports whether the value is ready.
module lab2_proc_BypassSelVRTL #(
    parameter int p_nbits    = 32,
    parameter int p_nbyp     = 3,
    parameter int p_zero_reg = 1,
    parameter int AW         = 5
) (
    input  logic [AW-1:0]             addr,
    input  logic [p_nbyp-1:0]         byp_val,
    input  logic [p_nbyp*AW-1:0]      byp_addr,
    input  logic [p_nbyp-1:0]         byp_rdy,
    input  logic [p_nbyp*p_nbits-1:0] byp_data,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [p_nbits-1:0]        wr_data,
    input  logic [p_nbits-1:0]        stored_data,
    input  logic                      stored_pending,
    output logic [p_nbits-1:0]        data,
    output logic                      stall
);

    always_comb begin
        // NOTE: data and stall get a value before any condition, so every
        // path assigns them and no latch is inferred.
        data  = stored_data;
        stall = stored_pending;

        if (wr_en && (wr_addr == addr)) begin
            data  = wr_data;
            stall = 1'b0;
        end

        // Walk oldest to youngest so the youngest matching producer overrides
        for (int j = p_nbyp - 1; j >= 0; j--) begin
            if (byp_val[j] && (byp_addr[j*AW +: AW] == addr)) begin
                data  = byp_data[j*p_nbits +: p_nbits];
                stall = ~byp_rdy[j];
            end
        end

        if ((p_zero_reg != 0) && (addr == '0)) begin
            data  = '0;
            stall = 1'b0;
        end
    end

endmodule

// File: rtl/lab2_proc_bypass_regfile.sv
// Register file with integrated bypass network and pending-write scoreboard;
// the D-stage operand source of the pipelined TinyRV2 processor.
module lab2_proc_bypass_regfile
    import lab2_proc_pkg::*;
#(
    parameter int p_nregs    = 32,
    parameter int p_nbits    = 32,
    parameter int p_nrd      = 2,
    parameter int p_nbyp     = 3,
    parameter int p_zero_reg = 1,
    localparam int AW        = addr_width(p_nregs)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [p_nrd*AW-1:0]       rd_addr,
    output logic [p_nrd*p_nbits-1:0]  rd_data,
    output logic [p_nrd-1:0]          rd_stall,
    input  logic [p_nbyp-1:0]         byp_val,
    input  logic [p_nbyp*AW-1:0]      byp_addr,
    input  logic [p_nbyp-1:0]         byp_rdy,
    input  logic [p_nbyp*p_nbits-1:0] byp_data,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [p_nbits-1:0]        wr_data,
    input  logic                      sb_set,
    input  logic [AW-1:0]             sb_set_addr,
    output logic [p_nregs-1:0]        sb_pending
);

    logic [p_nbits-1:0] regs [p_nregs];
    logic [p_nregs-1:0] pending;
    logic [p_nregs-1:0] pending_next;
    logic               wr_store;
    logic               sb_mark;

    // Register 0 absorbs writes and pending marks when hardwired to zero
    assign wr_store = wr_en  && !((p_zero_reg != 0) && (wr_addr == '0));
    assign sb_mark  = sb_set && !((p_zero_reg != 0) && (sb_set_addr == '0));

    // NOTE: the whole array is cleared by the asynchronous reset, so it maps
    // to flops rather than a RAM macro; that clear is part of the contract.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_nregs; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_store) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Retiring write clears first, then a new issue marks; a same-address set wins
    always_comb begin
        pending_next = pending;
        if (wr_en) begin
            pending_next[wr_addr] = 1'b0;
        end
        if (sb_mark) begin
            pending_next[sb_set_addr] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign sb_pending = pending;

    for (genvar i = 0; i < p_nrd; i++) begin : g_port
        logic [AW-1:0] addr;
        assign addr = rd_addr[i*AW +: AW];

        lab2_proc_BypassSelVRTL #(
            .p_nbits    (p_nbits),
            .p_nbyp     (p_nbyp),
            .p_zero_reg (p_zero_reg),
            .AW         (AW)
        ) u_sel (
            .addr           (addr),
            .byp_val        (byp_val),
            .byp_addr       (byp_addr),
            .byp_rdy        (byp_rdy),
            .byp_data       (byp_data),
            .wr_en          (wr_en),
            .wr_addr        (wr_addr),
            .wr_data        (wr_data),
            .stored_data    (regs[addr]),
            .stored_pending (pending[addr]),
            .data           (rd_data[i*p_nbits +: p_nbits]),
            .stall          (rd_stall[i])
        );
    end

endmodule
